// File: rtl/mtimer_if.sv
// Data-bus port of the machine timer.
// Master drives strobes and write data; the timer returns read data.
interface mtimer_if;
  logic        sel;
  logic [2:0]  addr;
  logic        write_en;
  logic        read_en;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output sel, addr, write_en, read_en, wdata,
    input  rdata
  );

  modport slave (
    input  sel, addr, write_en, read_en, wdata,
    output rdata
  );
endinterface

// File: rtl/mtimer.sv
// Machine timer: 64-bit mtime/mtimecmp with prescaler.
// Drives the level-sensitive timer interrupt sampled into MTIP.
module mtimer #(
  parameter int PRESCALE_W = 16
) (
  input  logic     clk,
  input  logic     reset,
  mtimer_if.slave  bus,
  output logic     intr_timer_o
);

  localparam logic [2:0] A_MLO = 3'd0;
  localparam logic [2:0] A_MHI = 3'd1;
  localparam logic [2:0] A_CLO = 3'd2;
  localparam logic [2:0] A_CHI = 3'd3;
  localparam logic [2:0] A_CTL = 3'd4;
  localparam logic [2:0] A_PRE = 3'd5;

  logic [63:0]           mtime_q, mtime_d;
  logic [63:0]           cmp_q, cmp_d;
  logic                  en_q, en_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic [31:0]           shadow_q, shadow_d;
  logic                  intr_q, intr_d;

  logic wr, rd, tick;

  assign wr   = bus.sel & bus.write_en;
  assign rd   = bus.sel & bus.read_en;
  assign tick = en_q && (pcnt_q == pre_q);

  always_comb begin
    bus.rdata = '0;
    if (rd) begin
      unique case (bus.addr)
        A_MLO:   bus.rdata = mtime_q[31:0];
        A_MHI:   bus.rdata = shadow_q;
        A_CLO:   bus.rdata = cmp_q[31:0];
        A_CHI:   bus.rdata = cmp_q[63:32];
        A_CTL:   bus.rdata = {31'd0, en_q};
        A_PRE:   bus.rdata = 32'(pre_q);
        default: bus.rdata = '0;
      endcase
    end
  end

  always_comb begin
    mtime_d  = mtime_q;
    cmp_d    = cmp_q;
    en_d     = en_q;
    pre_d    = pre_q;
    pcnt_d   = pcnt_q;
    shadow_d = shadow_q;
    intr_d   = (mtime_q >= cmp_q);

    if (en_q) begin
      pcnt_d = tick ? '0 : pcnt_q + 1'b1;
      if (tick) mtime_d = mtime_q + 64'd1;
    end

    if (rd && bus.addr == A_MLO) shadow_d = mtime_q[63:32];

    // A bus write to mtime overrides any tick this cycle.
    if (wr) begin
      unique case (bus.addr)
        A_MLO: mtime_d = {mtime_q[63:32], bus.wdata};
        A_MHI: mtime_d = {bus.wdata, mtime_q[31:0]};
        A_CLO: cmp_d   = {cmp_q[63:32], bus.wdata};
        A_CHI: cmp_d   = {bus.wdata, cmp_q[31:0]};
        A_CTL: begin
          en_d = bus.wdata[0];
          if (!bus.wdata[0]) pcnt_d = '0;
        end
        A_PRE: begin
          pre_d  = bus.wdata[PRESCALE_W-1:0];
          pcnt_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mtime_q  <= '0;
      cmp_q    <= '1;
      en_q     <= 1'b0;
      pre_q    <= '0;
      pcnt_q   <= '0;
      shadow_q <= '0;
      intr_q   <= 1'b0;
    end else begin
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      en_q     <= en_d;
      pre_q    <= pre_d;
      pcnt_q   <= pcnt_d;
      shadow_q <= shadow_d;
      intr_q   <= intr_d;
    end
  end

  assign intr_timer_o = intr_q;

endmodule

// File: tb/tb_mtimer.sv
// Randomized and directed checks of mtimer against a cycle model.
// Model tracks the timer as plain integers updated per clock.
module tb_mtimer;

  logic clk = 1'b0;
  logic reset;
  logic intr;

  mtimer_if bus ();

  mtimer #(.PRESCALE_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .intr_timer_o (intr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  longint unsigned m_time, m_cmp;
  bit              m_en;
  int unsigned     m_pre, m_cnt;
  bit [31:0]       m_sh;
  bit              m_intr;

  function automatic bit [31:0] m_read(input bit [2:0] a);
    case (a)
      3'd0: return m_time[31:0];
      3'd1: return m_sh;
      3'd2: return m_cmp[31:0];
      3'd3: return m_cmp[63:32];
      3'd4: return {31'd0, m_en};
      3'd5: return m_pre;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_time = 0; m_cmp = '1; m_en = 0;
    m_pre = 0; m_cnt = 0; m_sh = 0; m_intr = 0;
  endtask

  task automatic m_edge(input bit s, we, re,
                        input bit [2:0] a, input bit [31:0] wd);
    longint unsigned t;
    t = m_time;
    m_intr = (m_time >= m_cmp);
    if (s && re && a == 3'd0) m_sh = m_time[63:32];
    if (m_en) begin
      if (m_cnt == m_pre) begin
        m_cnt = 0;
        t = m_time + 1;
      end else m_cnt++;
    end
    if (s && we) begin
      case (a)
        3'd0: t = {m_time[63:32], wd};
        3'd1: t = {wd, m_time[31:0]};
        3'd2: m_cmp = {m_cmp[63:32], wd};
        3'd3: m_cmp = {wd, m_cmp[31:0]};
        3'd4: begin m_en = wd[0]; if (!wd[0]) m_cnt = 0; end
        3'd5: begin m_pre = wd[15:0]; m_cnt = 0; end
        default: ;
      endcase
    end
    m_time = t;
  endtask

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input bit s, we, re,
                      input bit [2:0] a, input bit [31:0] wd);
    @(negedge clk);
    bus.sel = s; bus.write_en = we; bus.read_en = re;
    bus.addr = a; bus.wdata = wd;
    #1;
    check("rdata", bus.rdata, (s && re) ? m_read(a) : 32'd0);
    @(posedge clk);
    m_edge(s, we, re, a, wd);
    #1;
    check("intr", intr, m_intr);
  endtask

  task automatic wr(input bit [2:0] a, input bit [31:0] d);
    step(1, 1, 0, a, d);
  endtask

  task automatic rd(input bit [2:0] a);
    step(1, 0, 1, a, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic rd_exp(input string tag, input bit [2:0] a,
                        input bit [31:0] exp);
    @(negedge clk);
    bus.sel = 1; bus.read_en = 1; bus.write_en = 0;
    bus.addr = a; bus.wdata = 0;
    #1;
    check(tag, bus.rdata, exp);
    @(posedge clk);
    m_edge(1, 0, 1, a, 0);
    #1;
    check("intr", intr, m_intr);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 0; bus.sel = 0; bus.write_en = 0; bus.read_en = 0;
    repeat (n) @(posedge clk);
    m_reset();
    #1;
    check("reset_intr", intr, 1'b0);
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    bit s, we, re;
    bit [2:0] a;
    bit [31:0] d;
    reset = 1;
    bus.sel = 0; bus.write_en = 0; bus.read_en = 0;
    bus.addr = 0; bus.wdata = 0;
    m_reset();
    do_reset(2);

    rd_exp("rst_mlo", 0, 32'd0);
    rd_exp("rst_chi", 3, 32'hFFFF_FFFF);
    rd_exp("rst_ctl", 4, 32'd0);
    idle(100);
    rd_exp("idle_mlo", 0, 32'd0);

    wr(5, 3);
    wr(4, 1);
    for (int i = 0; i < 40; i++) rd(0);
    rd_exp("pre3_40", 0, 32'd10);
    wr(5, 0);
    for (int i = 0; i < 6; i++) rd(0);

    wr(4, 0); wr(0, 0); wr(1, 0);
    wr(3, 0); wr(2, 20); wr(4, 1);
    idle(25);
    check("cmp_hit", intr, 1'b1);
    wr(2, 1000);
    idle(2);
    check("cmp_clr", intr, 1'b0);

    wr(4, 0); wr(1, 1); wr(0, 32'hFFFF_FFFE);
    wr(5, 0); wr(4, 1);
    idle(2);
    rd_exp("carry_lo", 0, 32'd0);
    rd_exp("carry_hi", 1, 32'd2);
    wr(1, 7);
    rd_exp("shadow_hi", 1, 32'd2);

    wr(0, 5);
    rd_exp("coll_5", 0, 32'd5);
    rd_exp("coll_6", 0, 32'd6);

    wr(4, 0); wr(3, '1); wr(2, '1);
    wr(1, '1); wr(0, 32'hFFFF_FFFE); wr(4, 1);
    idle(1);
    check("wrap_pre", intr, 1'b0);
    idle(1);
    check("wrap_max", intr, 1'b1);
    idle(1);
    check("wrap_zero", intr, 1'b0);

    for (int i = 0; i < 600; i++) begin
      s  = ($urandom_range(0, 9) != 0);
      we = ($urandom_range(0, 3) == 0);
      re = $urandom_range(0, 1);
      a  = 3'($urandom_range(0, 7));
      d  = $urandom;
      if (a == 5) d = $urandom_range(0, 5);
      if (a == 4) d = {d[31:1], ($urandom_range(0, 4) != 0)};
      if ((a == 1 || a == 3) && d[0]) d = $urandom_range(0, 1);
      if (a == 0 || a == 2) d = $urandom_range(0, 300);
      step(s, we, re, a, d);
      if (i == 300) do_reset(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
